// File: rtl/fpu_pkg.sv
// Shared FPU encodings and constants for the add/sub datapath back end.
package fpu_pkg;

  localparam logic [1:0] RND_RNE = 2'b00;
  localparam logic [1:0] RND_RTZ = 2'b01;
  localparam logic [1:0] RND_RUP = 2'b10;
  localparam logic [1:0] RND_RDN = 2'b11;

  localparam logic [1:0] SPC_FIN = 2'b00;
  localparam logic [1:0] SPC_INF = 2'b01;
  localparam logic [1:0] SPC_NAN = 2'b10;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam int          EXP_MAX = 255;
  localparam int          BIAS    = 127;

endpackage

// File: rtl/fpu_round_pack_if.sv
// Operand/result handshake bundle between the normalization corrector, round/pack stage and consumer.
interface fpu_round_pack_if #(
  parameter int EXP_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [23:0]      in_mant;
  logic [2:0]       in_grs;
  logic             in_second_shift_left;
  logic [1:0]       in_special;
  logic [1:0]       rnd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [2:0]       out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_grs, in_second_shift_left,
           in_special, rnd_mode, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_grs, in_second_shift_left,
           in_special, rnd_mode, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fpu_round_decide.sv
// Combinational round-increment and inexact decision from sign, mode, mantissa LSB and guard/round/sticky.
module fpu_round_decide
  import fpu_pkg::*;
(
  input  logic       i_sign,
  input  logic [1:0] i_mode,
  input  logic       i_lsb,
  input  logic [2:0] i_grs,
  output logic       o_inc,
  output logic       o_inexact
);

  logic w_g, w_r, w_s, w_any;

  assign w_g       = i_grs[2];
  assign w_r       = i_grs[1];
  assign w_s       = i_grs[0];
  assign w_any     = w_g | w_r | w_s;
  assign o_inexact = w_any;

  always_comb begin
    o_inc = 1'b0;
    case (i_mode)
      RND_RNE: o_inc = w_g & (w_r | w_s | i_lsb);
      RND_RTZ: o_inc = 1'b0;
      RND_RUP: o_inc = ~i_sign & w_any;
      RND_RDN: o_inc = i_sign & w_any;
      default: o_inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_round_pack.sv
// Two-stage round and pack: S1 registers corrected exponent and round decision, S2 rounds and packs the single.
module fpu_round_pack
  import fpu_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input logic             clk,
  input logic             rst,
  fpu_round_pack_if.slave bus
);

  localparam logic signed [EXP_W:0] E_ONE  = (EXP_W+1)'(1);
  localparam logic signed [EXP_W:0] E_ZERO = '0;
  localparam logic signed [EXP_W:0] E_MAX  = (EXP_W+1)'(EXP_MAX);

  logic                    w_s2_adv, w_s1_adv;
  logic                    w_inc, w_inexact;
  logic signed [EXP_W:0]   w_e1;

  logic                    r_s1_valid;
  logic signed [EXP_W:0]   r_s1_e1;
  logic                    r_s1_inc;
  logic                    r_s1_inexact;
  logic [23:0]             r_s1_mant;
  logic                    r_s1_sign;
  logic [1:0]              r_s1_special;
  logic [1:0]              r_s1_mode;

  logic [24:0]             w_m25;
  logic [23:0]             w_mant;
  logic signed [EXP_W:0]   w_e2;
  logic [31:0]             w_result;
  logic [2:0]              w_flags;

  logic                    r_s2_valid;
  logic [31:0]             r_s2_result;
  logic [2:0]              r_s2_flags;

  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign bus.in_ready = w_s1_adv;

  fpu_round_decide u_decide (
    .i_sign    (bus.in_sign),
    .i_mode    (bus.rnd_mode),
    .i_lsb     (bus.in_mant[0]),
    .i_grs     (bus.in_grs),
    .o_inc     (w_inc),
    .o_inexact (w_inexact)
  );

  // Sign-extend by one bit so the +/-1 adjustments can never wrap.
  assign w_e1 = $signed({bus.in_exp[EXP_W-1], bus.in_exp})
              - $signed({{EXP_W{1'b0}}, bus.in_second_shift_left});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_e1      <= '0;
      r_s1_inc     <= 1'b0;
      r_s1_inexact <= 1'b0;
      r_s1_mant    <= '0;
      r_s1_sign    <= 1'b0;
      r_s1_special <= SPC_FIN;
      r_s1_mode    <= RND_RNE;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_e1      <= w_e1;
        r_s1_inc     <= w_inc;
        r_s1_inexact <= w_inexact;
        r_s1_mant    <= bus.in_mant;
        r_s1_sign    <= bus.in_sign;
        r_s1_special <= bus.in_special;
        r_s1_mode    <= bus.rnd_mode;
      end
    end
  end

  assign w_m25 = {1'b0, r_s1_mant} + {24'd0, r_s1_inc};

  always_comb begin
    w_mant = w_m25[23:0];
    w_e2   = r_s1_e1;
    if (w_m25[24]) begin
      w_mant = w_m25[24:1];
      w_e2   = r_s1_e1 + E_ONE;
    end
  end

  always_comb begin
    w_result = {r_s1_sign, w_e2[7:0], w_mant[22:0]};
    w_flags  = {2'b00, r_s1_inexact};
    case (r_s1_special)
      SPC_INF: begin
        w_result = {r_s1_sign, 8'hFF, 23'h0};
        w_flags  = 3'b000;
      end
      SPC_FIN: begin
        if (w_mant == 24'd0) begin
          w_result = {r_s1_sign, 31'h0};
          w_flags  = 3'b000;
        end else if (w_e2 <= E_ZERO) begin
          w_result = {r_s1_sign, 31'h0};
          w_flags  = 3'b011;
        end else if (w_e2 >= E_MAX) begin
          w_flags = 3'b101;
          // Modes rounding away from zero in the sign's direction saturate to infinity.
          if (r_s1_mode == RND_RNE || (r_s1_mode == RND_RUP && !r_s1_sign) ||
              (r_s1_mode == RND_RDN && r_s1_sign))
            w_result = {r_s1_sign, 8'hFF, 23'h0};
          else
            w_result = {r_s1_sign, 8'hFE, 23'h7FFFFF};
        end
      end
      default: begin
        w_result = QNAN;
        w_flags  = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_result;
        r_s2_flags  <= w_flags;
      end
    end
  end

  assign bus.out_valid  = r_s2_valid;
  assign bus.out_result = r_s2_result;
  assign bus.out_flags  = r_s2_flags;

endmodule
